// File: rtl/mem_load_reader_if.sv
// Load-request and byte-memory handshake bundle for the 16-bit load reader.
// The master side is the CPU load stage plus the memory; the slave side is the reader.
interface mem_load_reader_if #(
    parameter int ADDR_W = 16
);
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_busy;
    logic              ld_valid;
    logic [15:0]       ld_data;
    logic              ld_err;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output ld_req, ld_addr, mem_ack, mem_rdata,
        input  ld_busy, ld_valid, ld_data, ld_err, mem_req, mem_addr
    );

    modport slave (
        input  ld_req, ld_addr, mem_ack, mem_rdata,
        output ld_busy, ld_valid, ld_data, ld_err, mem_req, mem_addr
    );
endinterface

// File: rtl/mem_load_reader.sv
// Load engine: fetches a little-endian 16-bit word as two byte reads over a
// req/ack memory handshake, with an optional per-byte ack timeout.
module mem_load_reader #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    mem_load_reader_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;

    // Width 1 when the timeout is disabled so the counter never collapses to zero bits.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The byte gives up on the cycle in which the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        lo_reg;
    logic [15:0]       data_reg;
    logic              err_reg;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

    // State register; reset abandons any load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: ack always wins over a timeout in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.ld_req) state_next = RD_LO;
            RD_LO: begin
                if (bus.mem_ack)     state_next = RD_HI;
                else if (timeout_hit) state_next = DONE;
            end
            RD_HI: begin
                if (bus.mem_ack || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from state; mem_req therefore drops with an async reset.
    always_comb begin
        bus.ld_busy  = (state_reg != IDLE);
        bus.mem_req  = (state_reg == RD_LO) || (state_reg == RD_HI);
        bus.ld_valid = (state_reg == DONE);
    end

    // Datapath: byte address, wait counter, low byte and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            addr_reg <= '0;
            lo_reg   <= 8'h00;
            data_reg <= 16'h0000;
            err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ld_req) begin
                        addr_reg <= bus.ld_addr;
                        cnt_reg  <= '0;
                    end
                end
                RD_LO: begin
                    if (bus.mem_ack) begin
                        lo_reg   <= bus.mem_rdata;
                        addr_reg <= addr_reg + ADDR_W'(1);
                        cnt_reg  <= '0;
                    end else if (timeout_hit) begin
                        data_reg <= 16'h0000;
                        err_reg  <= 1'b1;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                    end
                end
                RD_HI: begin
                    if (bus.mem_ack) begin
                        data_reg <= {bus.mem_rdata, lo_reg};
                        err_reg  <= 1'b0;
                        cnt_reg  <= '0;
                    end else if (timeout_hit) begin
                        data_reg <= 16'h0000;
                        err_reg  <= 1'b1;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = addr_reg;
    assign bus.ld_data  = data_reg;
    assign bus.ld_err   = err_reg;

endmodule

// File: tb/tb_mem_load_reader.sv
// Directed bench for mem_load_reader: a byte memory model answers requests with a
// configurable number of wait cycles; each scenario checks its own results.
module tb_mem_load_reader;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [7:0] mem [0:65535];
    bit         resp_en;
    int         ack_delay;
    bit         stray_ack;

    mem_load_reader_if #(.ADDR_W(16)) bus ();

    mem_load_reader #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks after ack_delay wait cycles, one byte per request.
    initial begin
        int wcnt;
        wcnt          = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) wcnt = 0;
            if (resp_en && bus.mem_req && !rst) begin
                if (wcnt >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                end else begin
                    bus.mem_ack   = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt          = 0;
                bus.mem_ack   = stray_ack;
                bus.mem_rdata = 8'hEE;
            end
        end
    end

    task automatic start_load(input logic [15:0] a);
        @(negedge clk);
        bus.ld_req  = 1'b1;
        bus.ld_addr = a;
        @(posedge clk);
        @(negedge clk);
        bus.ld_req  = 1'b0;
        bus.ld_addr = 16'h0000;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (bus.ld_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.ld_busy); end
        vectors++; if (bus.ld_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.ld_valid); end
        vectors++; if (bus.ld_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got=%h exp=0000", bus.ld_data); end
        vectors++; if (bus.ld_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.ld_err); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got=%b exp=0", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_memaddr got=%h exp=0000", bus.mem_addr); end
        $display("reset: busy=%b valid=%b data=%h err=%b mem_req=%b mem_addr=%h",
                 bus.ld_busy, bus.ld_valid, bus.ld_data, bus.ld_err, bus.mem_req, bus.mem_addr);
    endtask

    task automatic test_zero_wait();
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        resp_en = 1'b1; ack_delay = 0;
        start_load(16'h0010);
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL zw_memreq_lo got=%b exp=1", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 16'h0010) begin miscompares++; $display("FAIL zw_addr_lo got=%h exp=0010", bus.mem_addr); end
        vectors++; if (bus.ld_busy !== 1'b1) begin miscompares++; $display("FAIL zw_busy got=%b exp=1", bus.ld_busy); end
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 16'h0011) begin miscompares++; $display("FAIL zw_addr_hi got=%h exp=0011", bus.mem_addr); end
        vectors++; if (bus.ld_valid !== 1'b0) begin miscompares++; $display("FAIL zw_valid_early got=%b exp=0", bus.ld_valid); end
        @(negedge clk);
        vectors++; if (bus.ld_valid !== 1'b1) begin miscompares++; $display("FAIL zw_valid got=%b exp=1", bus.ld_valid); end
        vectors++; if (bus.ld_data !== 16'h1234) begin miscompares++; $display("FAIL zw_data got=%h exp=1234", bus.ld_data); end
        vectors++; if (bus.ld_err !== 1'b0) begin miscompares++; $display("FAIL zw_err got=%b exp=0", bus.ld_err); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL zw_memreq_done got=%b exp=0", bus.mem_req); end
        $display("zero_wait: addr=0010 data=%h err=%b", bus.ld_data, bus.ld_err);
        @(negedge clk);
        vectors++; if (bus.ld_valid !== 1'b0) begin miscompares++; $display("FAIL zw_valid_pulse got=%b exp=0", bus.ld_valid); end
        vectors++; if (bus.ld_busy !== 1'b0) begin miscompares++; $display("FAIL zw_busy_after got=%b exp=0", bus.ld_busy); end
        vectors++; if (bus.ld_data !== 16'h1234) begin miscompares++; $display("FAIL zw_data_hold got=%h exp=1234", bus.ld_data); end
    endtask

    task automatic test_wait_states();
        int valid_cyc;
        logic [15:0] data_seen;
        logic        err_seen;
        valid_cyc = 0; data_seen = 16'h0; err_seen = 1'b0;
        mem[16'h0101] = 8'h9A;
        mem[16'h0102] = 8'hBC;
        resp_en = 1'b1; ack_delay = 2;
        start_load(16'h0101);
        for (int c = 1; c <= 20 && valid_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.ld_valid) begin
                valid_cyc = c; data_seen = bus.ld_data; err_seen = bus.ld_err;
            end else if (c <= 6) begin
                vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL ws_memreq c=%0d got=%b exp=1", c, bus.mem_req); end
                vectors++;
                if (bus.mem_addr !== ((c <= 3) ? 16'h0101 : 16'h0102)) begin
                    miscompares++; $display("FAIL ws_addr c=%0d got=%h exp=%h", c, bus.mem_addr, (c <= 3) ? 16'h0101 : 16'h0102);
                end
            end
        end
        vectors++; if (valid_cyc != 7) begin miscompares++; $display("FAIL ws_latency got=%0d exp=7", valid_cyc); end
        vectors++; if (data_seen !== 16'hBC9A) begin miscompares++; $display("FAIL ws_data got=%h exp=bc9a", data_seen); end
        vectors++; if (err_seen !== 1'b0) begin miscompares++; $display("FAIL ws_err got=%b exp=0", err_seen); end
        $display("wait_states: addr=0101 data=%h err=%b latency=%0d", data_seen, err_seen, valid_cyc);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'hCD;
        mem[16'h0000] = 8'hAB;
        resp_en = 1'b1; ack_delay = 0;
        start_load(16'hFFFF);
        vectors++; if (bus.mem_addr !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_addr_lo got=%h exp=ffff", bus.mem_addr); end
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr_hi got=%h exp=0000", bus.mem_addr); end
        @(negedge clk);
        vectors++; if (bus.ld_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got=%b exp=1", bus.ld_valid); end
        vectors++; if (bus.ld_data !== 16'hABCD) begin miscompares++; $display("FAIL wrap_data got=%h exp=abcd", bus.ld_data); end
        $display("wrap: addr=ffff data=%h err=%b", bus.ld_data, bus.ld_err);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int valid_cyc;
        logic [15:0] data_seen;
        logic        err_seen;
        valid_cyc = 0; data_seen = 16'hFFFF; err_seen = 1'b0;
        resp_en = 1'b0;
        start_load(16'h0300);
        for (int c = 1; c <= 30 && valid_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.ld_valid) begin
                valid_cyc = c; data_seen = bus.ld_data; err_seen = bus.ld_err;
            end else if (c == 15) begin
                vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL to_memreq_held got=%b exp=1", bus.mem_req); end
            end
        end
        vectors++; if (valid_cyc != 16) begin miscompares++; $display("FAIL to_latency got=%0d exp=16", valid_cyc); end
        vectors++; if (err_seen !== 1'b1) begin miscompares++; $display("FAIL to_err got=%b exp=1", err_seen); end
        vectors++; if (data_seen !== 16'h0000) begin miscompares++; $display("FAIL to_data got=%h exp=0000", data_seen); end
        $display("timeout: addr=0300 data=%h err=%b latency=%0d", data_seen, err_seen, valid_cyc);
        @(negedge clk);
        @(negedge clk);
        stray_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (bus.ld_busy !== 1'b0) begin miscompares++; $display("FAIL to_late_busy got=%b exp=0", bus.ld_busy); end
            vectors++; if (bus.ld_valid !== 1'b0) begin miscompares++; $display("FAIL to_late_valid got=%b exp=0", bus.ld_valid); end
            vectors++; if (bus.ld_data !== 16'h0000) begin miscompares++; $display("FAIL to_late_data got=%h exp=0000", bus.ld_data); end
        end
        stray_ack = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int valid_cyc;
        int extra_valid;
        int extra_busy;
        logic [15:0] data_seen;
        valid_cyc = 0; extra_valid = 0; extra_busy = 0; data_seen = 16'h0;
        mem[16'h0040] = 8'h78;
        mem[16'h0041] = 8'h56;
        mem[16'h0200] = 8'h11;
        mem[16'h0201] = 8'h22;
        resp_en = 1'b1; ack_delay = 1;
        start_load(16'h0040);
        for (int c = 1; c <= 20 && valid_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin bus.ld_req = 1'b1; bus.ld_addr = 16'h0200; end
            if (c == 3) begin bus.ld_req = 1'b0; bus.ld_addr = 16'h0000; end
            if (bus.ld_valid) begin valid_cyc = c; data_seen = bus.ld_data; end
        end
        vectors++; if (valid_cyc != 5) begin miscompares++; $display("FAIL bi_latency got=%0d exp=5", valid_cyc); end
        vectors++; if (data_seen !== 16'h5678) begin miscompares++; $display("FAIL bi_data got=%h exp=5678", data_seen); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.ld_valid) extra_valid++;
            if (bus.ld_busy) extra_busy++;
        end
        vectors++; if (extra_valid != 0) begin miscompares++; $display("FAIL bi_second_valid got=%0d exp=0", extra_valid); end
        vectors++; if (extra_busy != 0) begin miscompares++; $display("FAIL bi_second_busy got=%0d exp=0", extra_busy); end
        vectors++; if (bus.ld_data !== 16'h5678) begin miscompares++; $display("FAIL bi_data_hold got=%h exp=5678", bus.ld_data); end
        $display("busy_ignore: addr=0040 data=%h latency=%0d extra_valid=%0d", data_seen, valid_cyc, extra_valid);
    endtask

    task automatic test_reset_mid_load();
        int valid_seen;
        valid_seen = 0;
        mem[16'h0050] = 8'h01;
        mem[16'h0051] = 8'h02;
        resp_en = 1'b1; ack_delay = 3;
        start_load(16'h0050);
        for (int c = 2; c <= 5; c++) @(negedge clk);
        vectors++; if (bus.mem_addr !== 16'h0051) begin miscompares++; $display("FAIL rm_in_rdhi got=%h exp=0051", bus.mem_addr); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_memreq got=%b exp=0", bus.mem_req); end
        vectors++; if (bus.ld_busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got=%b exp=0", bus.ld_busy); end
        vectors++; if (bus.mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rm_memaddr got=%h exp=0000", bus.mem_addr); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (bus.ld_valid) valid_seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ld_valid) valid_seen++;
        end
        vectors++; if (valid_seen != 0) begin miscompares++; $display("FAIL rm_no_valid got=%0d exp=0", valid_seen); end
        $display("reset_mid_load: addr=0050 abandoned valid_pulses=%0d", valid_seen);
        ack_delay = 0;
        start_load(16'h0010);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.ld_valid !== 1'b1) begin miscompares++; $display("FAIL rm_next_valid got=%b exp=1", bus.ld_valid); end
        vectors++; if (bus.ld_data !== 16'h1234) begin miscompares++; $display("FAIL rm_next_data got=%h exp=1234", bus.ld_data); end
        vectors++; if (bus.ld_err !== 1'b0) begin miscompares++; $display("FAIL rm_next_err got=%b exp=0", bus.ld_err); end
        $display("post_reset_load: addr=0010 data=%h err=%b", bus.ld_data, bus.ld_err);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resp_en     = 1'b1;
        ack_delay   = 0;
        stray_ack   = 1'b0;
        bus.ld_req  = 1'b0;
        bus.ld_addr = 16'h0000;
        rst         = 1'b1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_zero_wait();
        test_wait_states();
        test_wrap();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
